fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen.sv | 128 ++++++++++++
 tb/tb_fetch_pc_gen.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: PC register, JAL/branch next-PC prediction and a 2-bit BHT.
// The BHT is built only when BHT_PREDICT_EN is defined; otherwise branches predict not-taken.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module fetch_pc_gen #(
   parameter logic [`PC_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned          BHT_ENTRIES = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic                      F_stall_i,
   input  logic                      E_redirect_i,
   input  logic [`PC_WIDTH-1:0]      E_redirect_PC_i,
   input  logic                      E_train_vaild_i,
   input  logic [`PC_WIDTH-1:0]      E_train_PC_i,
   input  logic                      E_train_taken_i,
   output logic [`PC_WIDTH-1:0]      imem_addr_o,
   input  logic [`INSTR_WIDTH-1:0]   imem_instr_i,
   output logic [`INSTR_WIDTH-1:0]   instr_o,
   output logic [`PC_WIDTH-1:0]      F_PC_o,
   output logic [`PC_WIDTH-1:0]      F_nPC_o,
   output logic                      F_commit_o,
   output logic                      F_train_predict_o,
   output logic                      F_train_vaild_o
);

   localparam int unsigned PC_W  = `PC_WIDTH;
   localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] imm_b, imm_j, npc;
   logic            is_branch, is_jal, bht_taken;

   // Zero-latency fetch: the instruction memory is addressed straight from the PC register.
   assign imem_addr_o = pc_q;
   assign F_PC_o      = pc_q;
   assign instr_o     = imem_instr_i;

   assign is_branch = (imem_instr_i[6:0] == OP_BRANCH);
   assign is_jal    = (imem_instr_i[6:0] == OP_JAL);

   assign imm_b = {{(PC_W-12){imem_instr_i[31]}}, imem_instr_i[7], imem_instr_i[30:25],
                   imem_instr_i[11:8], 1'b0};
   assign imm_j = {{(PC_W-20){imem_instr_i[31]}}, imem_instr_i[19:12], imem_instr_i[20],
                   imem_instr_i[30:21], 1'b0};

   always_comb begin : next_pc
      npc = pc_q + PC_W'(4);
      if (is_jal) begin
         npc = pc_q + imm_j;
      end else if (is_branch && bht_taken) begin
         npc = pc_q + imm_b;
      end
   end

   // Redirect wins over stall.
   always_comb begin : pc_sel
      pc_d = npc;
      if (E_redirect_i) begin
         pc_d = E_redirect_PC_i;
      end else if (F_stall_i) begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin : pc_reg
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign F_nPC_o           = npc;
   assign F_commit_o        = rst_n && !E_redirect_i;
   assign F_train_vaild_o   = is_branch;
   assign F_train_predict_o = is_branch && bht_taken;

`ifdef BHT_PREDICT_EN
   logic [1:0]       bht_q [BHT_ENTRIES];
   logic [1:0]       bht_d [BHT_ENTRIES];
   logic [IDX_W-1:0] lookup_idx, train_idx;
   logic             unused_train;

   assign lookup_idx   = pc_q[IDX_W+1:2];
   assign train_idx    = E_train_PC_i[IDX_W+1:2];
   assign unused_train = ^{E_train_PC_i[PC_W-1:IDX_W+2], E_train_PC_i[1:0]};

   // Lookup reads the registered counters, so a same-cycle train is not bypassed.
   assign bht_taken = bht_q[lookup_idx][1];

   always_comb begin : bht_update
      bht_d = bht_q;
      if (E_train_vaild_i) begin
         if (E_train_taken_i) begin
            if (bht_q[train_idx] != 2'b11) begin
               bht_d[train_idx] = bht_q[train_idx] + 2'b01;
            end
         end else if (bht_q[train_idx] != 2'b00) begin
            bht_d[train_idx] = bht_q[train_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin : bht_reg
      if (!rst_n) begin
         for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         bht_q <= bht_d;
      end
   end
`else
   logic unused_train;

   assign bht_taken    = 1'b0;
   assign unused_train = ^{E_train_vaild_i, E_train_PC_i, E_train_taken_i};
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: directed scenarios plus randomized traffic
// against an instruction-level reference model (expects follow BHT_PREDICT_EN if defined).
module tb_fetch_pc_gen;

   localparam int unsigned ENTRIES = 16;

   typedef enum int {K_ADDI, K_JAL, K_BR, K_JALR, K_RAND} kind_e;

   logic        clk_i = 1'b0;
   logic        rst_n;
   logic        F_stall_i, E_redirect_i, E_train_vaild_i, E_train_taken_i;
   logic [31:0] E_redirect_PC_i, E_train_PC_i, imem_instr_i;
   logic [31:0] imem_addr_o, instr_o, F_PC_o, F_nPC_o;
   logic        F_commit_o, F_train_predict_o, F_train_vaild_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   logic [31:0] m_pc;
   int          m_cnt [ENTRIES];
   kind_e       cur_kind;
   logic [31:0] cur_imm;

`ifdef BHT_PREDICT_EN
   localparam bit BHT_ON = 1'b1;
`else
   localparam bit BHT_ON = 1'b0;
`endif

   fetch_pc_gen dut (
      .clk_i             (clk_i),
      .rst_n             (rst_n),
      .F_stall_i         (F_stall_i),
      .E_redirect_i      (E_redirect_i),
      .E_redirect_PC_i   (E_redirect_PC_i),
      .E_train_vaild_i   (E_train_vaild_i),
      .E_train_PC_i      (E_train_PC_i),
      .E_train_taken_i   (E_train_taken_i),
      .imem_addr_o       (imem_addr_o),
      .imem_instr_i      (imem_instr_i),
      .instr_o           (instr_o),
      .F_PC_o            (F_PC_o),
      .F_nPC_o           (F_nPC_o),
      .F_commit_o        (F_commit_o),
      .F_train_predict_o (F_train_predict_o),
      .F_train_vaild_o   (F_train_vaild_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic int idx(logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_taken(logic [31:0] pc);
      return BHT_ON && (m_cnt[idx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_npc();
      if (cur_kind == K_JAL) return m_pc + cur_imm;
      if (cur_kind == K_BR && m_taken(m_pc)) return m_pc + cur_imm;
      return m_pc + 32'd4;
   endfunction

   function automatic logic [31:0] enc(kind_e k, logic [31:0] imm, logic [31:0] rnd);
      logic [31:0] r;
      r = rnd;
      case (k)
         K_ADDI: return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b0010011};
         K_JAL:  return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
         K_BR:   return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
         K_JALR: return {imm[11:0], 5'd1, 3'b000, 5'd1, 7'b1100111};
         default: begin
            if (r[6:0] == 7'b1100011 || r[6:0] == 7'b1101111) r[2] = ~r[2];
            return r;
         end
      endcase
   endfunction

   task automatic set_instr(kind_e k, logic [31:0] imm);
      cur_kind     = k;
      cur_imm      = imm;
      imem_instr_i = enc(k, imm, $urandom());
   endtask

   task automatic idle();
      F_stall_i       = 1'b0;
      E_redirect_i    = 1'b0;
      E_redirect_PC_i = 32'h0;
      E_train_vaild_i = 1'b0;
      E_train_PC_i    = 32'h0;
      E_train_taken_i = 1'b0;
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      for (int i = 0; i < int'(ENTRIES); i++) m_cnt[i] = 1;
   endtask

   // Advance one clock: model the architectural effect of the inputs present at the edge.
   task automatic tick();
      logic [31:0] nxt;
      int          k;
      nxt = E_redirect_i ? E_redirect_PC_i : (F_stall_i ? m_pc : m_npc());
      k   = idx(E_train_PC_i);
      @(posedge clk_i);
      #1;
      if (rst_n) begin
         m_pc = nxt;
         if (E_train_vaild_i) begin
            if (E_train_taken_i) begin
               if (m_cnt[k] < 3) m_cnt[k]++;
            end else if (m_cnt[k] > 0) begin
               m_cnt[k]--;
            end
         end
      end
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if (F_commit_o !== 1'b0 || F_PC_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: commit=%b pc=%h want commit=0 pc=00000000", F_commit_o, F_PC_o);
      end
      @(posedge clk_i);
      #2;
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (F_commit_o !== 1'b1 || F_train_vaild_o !== 1'b0 || F_PC_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_release: commit=%b valid=%b pc=%h want 1 0 00000000",
                  F_commit_o, F_train_vaild_o, F_PC_o);
      end
      tick();
      n_tests++;
      if (F_PC_o !== 32'h4) begin
         n_fail++;
         $display("FAIL seq_pc4: got %h want 00000004", F_PC_o);
      end
      tick();
      n_tests++;
      if (F_PC_o !== 32'h8 || F_commit_o !== 1'b1) begin
         n_fail++;
         $display("FAIL seq_pc8: pc=%h commit=%b want 00000008 1", F_PC_o, F_commit_o);
      end
   endtask

   task automatic test_jal();
      idle();
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h10;
      #1;
      n_tests++;
      if (F_commit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL redirect_commit: got %b want 0", F_commit_o);
      end
      tick();
      idle();
      set_instr(K_JAL, 32'h20);
      #1;
      n_tests++;
      if (F_PC_o !== 32'h10 || F_nPC_o !== 32'h30) begin
         n_fail++;
         $display("FAIL jal_fwd_npc: pc=%h npc=%h want 00000010 00000030", F_PC_o, F_nPC_o);
      end
      tick();
      n_tests++;
      if (F_PC_o !== 32'h30) begin
         n_fail++;
         $display("FAIL jal_fwd_pc: got %h want 00000030", F_PC_o);
      end
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h10;
      tick();
      idle();
      set_instr(K_JAL, 32'hFFFF_FFF0);
      #1;
      n_tests++;
      if (F_nPC_o !== 32'h0) begin
         n_fail++;
         $display("FAIL jal_back_npc: got %h want 00000000", F_nPC_o);
      end
      tick();
      n_tests++;
      if (F_PC_o !== 32'h0) begin
         n_fail++;
         $display("FAIL jal_back_pc: got %h want 00000000", F_PC_o);
      end
   endtask

   task automatic test_bht();
      idle();
      set_instr(K_ADDI, 32'h1);
      E_train_vaild_i = 1'b1; E_train_PC_i = 32'h40; E_train_taken_i = 1'b1;
      tick();
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h40;
      tick();
      idle();
      set_instr(K_BR, 32'h8);
      #1;
      n_tests++;
      if (F_train_vaild_o !== 1'b1 || F_train_predict_o !== BHT_ON ||
          F_nPC_o !== (BHT_ON ? 32'h48 : 32'h44)) begin
         n_fail++;
         $display("FAIL bht_trained_beq: valid=%b pred=%b npc=%h want 1 %b %h", F_train_vaild_o,
                  F_train_predict_o, F_nPC_o, BHT_ON, BHT_ON ? 32'h48 : 32'h44);
      end
   endtask

   task automatic test_stall();
      idle();
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h20;
      tick();
      idle();
      set_instr(K_ADDI, 32'h5);
      F_stall_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (F_PC_o !== 32'h20 || F_commit_o !== 1'b1 || F_nPC_o !== 32'h24) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: pc=%h commit=%b npc=%h want 00000020 1 00000024",
                     c, F_PC_o, F_commit_o, F_nPC_o);
         end
         tick();
      end
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h100;
      #1;
      n_tests++;
      if (F_commit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_redirect_commit: got %b want 0", F_commit_o);
      end
      tick();
      idle();
      #1;
      n_tests++;
      if (F_PC_o !== 32'h100 || F_commit_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_redirect_pc: pc=%h commit=%b want 00000100 1", F_PC_o, F_commit_o);
      end
   endtask

   task automatic test_saturation();
      idle();
      set_instr(K_ADDI, 32'h0);
      for (int c = 0; c < 6; c++) begin
         E_redirect_i = 1'b1; E_redirect_PC_i = 32'h0;
         E_train_vaild_i = 1'b1; E_train_PC_i = 32'h0; E_train_taken_i = (c < 5);
         tick();
      end
      idle();
      F_stall_i = 1'b1;
      set_instr(K_BR, 32'h8);
      #1;
      n_tests++;
      if (F_train_predict_o !== BHT_ON) begin
         n_fail++;
         $display("FAIL sat_after_5t1n: pred=%b want %b", F_train_predict_o, BHT_ON);
      end
      E_train_vaild_i = 1'b1; E_train_PC_i = 32'h0; E_train_taken_i = 1'b0;
      #1;
      n_tests++;
      if (F_train_predict_o !== BHT_ON) begin
         n_fail++;
         $display("FAIL no_bypass_dec: pred=%b want %b", F_train_predict_o, BHT_ON);
      end
      tick();
      E_train_taken_i = 1'b1;
      #1;
      n_tests++;
      if (F_train_predict_o !== 1'b0 || F_nPC_o !== 32'h4) begin
         n_fail++;
         $display("FAIL no_bypass_inc: pred=%b npc=%h want 0 00000004", F_train_predict_o, F_nPC_o);
      end
      tick();
      E_train_vaild_i = 1'b0;
      #1;
      n_tests++;
      if (F_train_predict_o !== BHT_ON || F_nPC_o !== (BHT_ON ? 32'h8 : 32'h4)) begin
         n_fail++;
         $display("FAIL post_train_pred: pred=%b npc=%h want %b %h", F_train_predict_o, F_nPC_o,
                  BHT_ON, BHT_ON ? 32'h8 : 32'h4);
      end
   endtask

   task automatic test_async_reset();
      idle();
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h80;
      tick();
      idle();
      set_instr(K_ADDI, 32'h3);
      E_train_vaild_i = 1'b1; E_train_PC_i = 32'h0; E_train_taken_i = 1'b1;
      E_redirect_i = 1'b1; E_redirect_PC_i = 32'h200;
      n_tests++;
      if (F_PC_o !== 32'h80) begin
         n_fail++;
         $display("FAIL pre_reset_pc: got %h want 00000080", F_PC_o);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++;
      if (F_PC_o !== 32'h0 || F_commit_o !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: pc=%h commit=%b want 00000000 0", F_PC_o, F_commit_o);
      end
      tick();
      idle();
      #2;
      rst_n = 1'b1;
      set_instr(K_BR, 32'h8);
      #1;
      n_tests++;
      if (F_PC_o !== 32'h0 || F_commit_o !== 1'b1 || F_train_predict_o !== 1'b0 ||
          F_nPC_o !== 32'h4) begin
         n_fail++;
         $display("FAIL reset_counters: pc=%h commit=%b pred=%b npc=%h want 00000000 1 0 00000004",
                  F_PC_o, F_commit_o, F_train_predict_o, F_nPC_o);
      end
   endtask

   task automatic test_random();
      kind_e       k;
      logic [31:0] imm;
      int          v;
      for (int c = 0; c < 400; c++) begin
         tick();
         idle();
         F_stall_i       = ($urandom_range(0, 3) == 0);
         E_redirect_i    = ($urandom_range(0, 9) == 0);
         E_redirect_PC_i = 32'($urandom_range(0, 255)) << 2;
         E_train_vaild_i = $urandom_range(0, 1) == 1;
         E_train_PC_i    = 32'($urandom_range(0, 63)) << 2;
         E_train_taken_i = $urandom_range(0, 1) == 1;
         k = kind_e'($urandom_range(0, 4));
         case (k)
            K_JAL: begin v = int'($urandom_range(0, 1048575)) - 524288; imm = 32'(v * 2); end
            K_BR:  begin v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v * 2); end
            default: imm = 32'($urandom_range(0, 4095));
         endcase
         set_instr(k, imm);
         #1;
         n_tests++;
         if (F_PC_o !== m_pc || imem_addr_o !== m_pc || instr_o !== imem_instr_i) begin
            n_fail++;
            $display("FAIL rnd_pc[%0d]: pc=%h addr=%h want %h", c, F_PC_o, imem_addr_o, m_pc);
         end
         n_tests++;
         if (F_nPC_o !== m_npc()) begin
            n_fail++;
            $display("FAIL rnd_npc[%0d]: got %h want %h", c, F_nPC_o, m_npc());
         end
         n_tests++;
         if (F_commit_o !== !E_redirect_i || F_train_vaild_o !== (k == K_BR) ||
             F_train_predict_o !== (k == K_BR && m_taken(m_pc))) begin
            n_fail++;
            $display("FAIL rnd_flags[%0d]: commit=%b valid=%b pred=%b want %b %b %b", c,
                     F_commit_o, F_train_vaild_o, F_train_predict_o, !E_redirect_i,
                     k == K_BR, k == K_BR && m_taken(m_pc));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      set_instr(K_ADDI, 32'h1);
      test_reset();
      test_jal();
      test_bht();
      test_stall();
      test_saturation();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
